prefetcher_ar_arbiter: RTL
==========================

# prefetcher_ar_arbiter

Shares one master AXI read channel (AR request + R response routing) between NUM_PORTS prefetcher controllers feeding the same DDR port. Round-robin arbitration on AR, an outstanding-ID ownership table, and R-beat steering back to the port that issued each ID. Sits between the prefetcher controllers' master AXI ports and the DDR-side master.

## Interface
- NUM_PORTS, 4, number of requesting controllers (2..8)
- ADDR_BITS, 64, AR address width
- BURST_LEN_WIDTH, 8, AR len width
- TID_WIDTH, 8, AXI ID width
- OUTSTANDING_DEPTH, 4, ownership-table entries
- CNT_WIDTH, 4, per-entry outstanding-burst counter width
- clk  in  1  clock
- resetN  in  1  reset; one clock, reset is asynchronous and active-low
- p_ar_valid  in  NUM_PORTS  per-port AR valid
- p_ar_ready  out  NUM_PORTS  per-port AR ready
- p_ar_addr  in  NUM_PORTS*ADDR_BITS  per-port AR address, port i at slice i
- p_ar_len  in  NUM_PORTS*BURST_LEN_WIDTH  per-port burst len
- p_ar_id  in  NUM_PORTS*TID_WIDTH  per-port ID
- p_r_valid  out  NUM_PORTS  steered R valid
- p_r_ready  in  NUM_PORTS  per-port R ready
- m_ar_valid  out  1  DDR AR valid
- m_ar_ready  in  1  DDR AR ready
- m_ar_addr / m_ar_len / m_ar_id  out  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  latched winner request
- m_r_valid  in  1  DDR R valid
- m_r_ready  out  1  DDR R ready
- m_r_id  in  TID_WIDTH  R beat ID
- m_r_last  in  1  last beat of burst
- err_unknown_id  out  1  sticky: R beat with no table entry

## Operation
- FSM: ST_ARB_IDLE, ST_ARB_ISSUE.
- Port i eligible iff p_ar_valid[i] and: its ID matches a valid entry owned by port i with cnt < 2^CNT_WIDTH-1, or ID absent and a free entry exists. ID owned by another port -> port i stalled (AXI same-ID ordering).
- IDLE: winner = first eligible port at/after rr_ptr (wrap NUM_PORTS-1 -> 0). p_ar_ready[winner]=1 (others 0); on handshake latch addr/len/id/port, rr_ptr <= winner+1 mod NUM_PORTS, go ISSUE. No eligible -> stay, all ready 0.
- ISSUE: m_ar_valid=1, outputs stable. On m_ar_ready: allocate (lowest free index, owner=port, cnt=1) or increment existing entry; go IDLE. All p_ar_ready=0.
- R steering (combinational): hit = valid entry with id==m_r_id. Hit: p_r_valid[owner]=m_r_valid, m_r_ready=p_r_ready[owner]. Miss: m_r_ready=1 (beat dropped), err_unknown_id set on m_r_valid.
- On m_r_valid&m_r_ready&m_r_last&hit: cnt-1; entry freed at 0.
- Same-cycle allocate/increment and last-beat decrement on one entry: net cnt unchanged. Freed entry usable next cycle.
- Eligibility uses the table as registered at cycle start.

## Timing
- Reset: state ST_ARB_IDLE, rr_ptr 0, table invalid, m_ar_valid 0, m_ar_addr/len/id 0, p_ar_ready 0, err_unknown_id 0; p_r_valid/m_r_ready follow combinational rules (m_r_ready=1 on miss).
- Port handshake cycle N -> m_ar_valid at N+1; back-to-back AR peak rate 1 per 2 cycles.
- m_ar_valid never drops without m_ar_ready. R path zero latency.
- Reset mid-burst discards table; subsequent beats of old IDs dropped and flagged.

## Configuration
- PREF_ARB_STATS_EN defined: per-port 32-bit grant counters (saturating, increment on m_ar handshake) plus 32-bit stall counter (cycles with a valid request and no grant), output on stat_grants (NUM_PORTS*32) and stat_stalls (32), cleared on reset. Undefined: ports and logic absent, behaviour otherwise identical.

## Structure
- Shared package pref_arb_pkg: arb_state_t enum, ownership entry struct {valid, id, owner, cnt}, STAT_WIDTH=32.
- Sub-module rr_picker (NUM_PORTS-wide request vector + pointer -> one-hot grant, valid).

## Test plan
- Ports 0,2 request at reset -> port 0 granted, m_ar_valid cycle after handshake; then port 2; then port 0 again (rr wrap).
- m_ar_ready held 0 five cycles -> m_ar_valid and addr/len/id stable; p_ar_ready all 0.
- Port 1 issues id 3; port 3 requests id 3 -> port 3 stalled until port 1's m_r_last beat, then granted.
- Fill 4 entries with ids 1..4; port requests id 5 -> no grant until a last beat frees an entry.
- m_r_valid id 3 with p_r_ready[owner]=0 -> m_r_ready 0, p_r_valid[owner] 1; id 9 unknown -> m_r_ready 1, err_unknown_id 1 sticky.
- Same cycle: id 3 cnt=1 last beat and new id 3 AR handshake -> cnt stays 1, entry remains valid.

Source files
------------

// File: rtl/pref_arb_pkg.sv
// pref_arb_pkg: shared FSM state and ownership-table entry types for prefetcher_ar_arbiter.
// Entry fields are sized for the widest legal configuration; users slice what they need.
package pref_arb_pkg;
   localparam int STAT_WIDTH = 32;
   localparam int ENT_ID_BITS = 32;
   localparam int ENT_OWNER_BITS = 3;
   localparam int ENT_CNT_BITS = 16;
   typedef enum logic [0:0] {ST_ARB_IDLE, ST_ARB_ISSUE} arb_state_t;
   typedef struct packed {
      logic valid;
      logic [ENT_ID_BITS-1:0] id;
      logic [ENT_OWNER_BITS-1:0] owner;
      logic [ENT_CNT_BITS-1:0] cnt;
   } own_entry_t;
endpackage

// File: rtl/prefetcher_ar_arbiter_rr_picker.sv
// rr_picker: one-hot grant to the first requester at or after ptr, wrapping N-1 -> 0.
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic                 valid
);
   logic [$clog2(N)-1:0] j;
   always_comb begin
      grant = '0;
      valid = 1'b0;
      j = '0;
      for (int k = 0; k < N; k++) begin
         j = $clog2(N)'((int'(ptr) + k) % N);
         if (!valid && req[j]) begin
            valid = 1'b1;
            grant[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/prefetcher_ar_arbiter.sv
// prefetcher_ar_arbiter: round-robin AR sharing between prefetcher ports with ID-ownership R steering.
// Defining PREF_ARB_STATS_EN adds per-port grant counters and a stall counter.
module prefetcher_ar_arbiter
   import pref_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_BITS = 64,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int TID_WIDTH = 8,
   parameter int OUTSTANDING_DEPTH = 4,
   parameter int CNT_WIDTH = 4
) (
   input  logic                                 clk,
   input  logic                                 resetN,
   input  logic [NUM_PORTS-1:0]                 p_ar_valid,
   output logic [NUM_PORTS-1:0]                 p_ar_ready,
   input  logic [NUM_PORTS*ADDR_BITS-1:0]       p_ar_addr,
   input  logic [NUM_PORTS*BURST_LEN_WIDTH-1:0] p_ar_len,
   input  logic [NUM_PORTS*TID_WIDTH-1:0]       p_ar_id,
   output logic [NUM_PORTS-1:0]                 p_r_valid,
   input  logic [NUM_PORTS-1:0]                 p_r_ready,
   output logic                                 m_ar_valid,
   input  logic                                 m_ar_ready,
   output logic [ADDR_BITS-1:0]                 m_ar_addr,
   output logic [BURST_LEN_WIDTH-1:0]           m_ar_len,
   output logic [TID_WIDTH-1:0]                 m_ar_id,
   input  logic                                 m_r_valid,
   output logic                                 m_r_ready,
   input  logic [TID_WIDTH-1:0]                 m_r_id,
   input  logic                                 m_r_last,
   output logic                                 err_unknown_id
`ifdef PREF_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*STAT_WIDTH-1:0]      stat_grants,
   output logic [STAT_WIDTH-1:0]                stat_stalls
`endif
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int IW = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
   localparam logic [ENT_CNT_BITS-1:0] CNT_FULL = ENT_CNT_BITS'((1 << CNT_WIDTH) - 1);
   arb_state_t state, state_n;
   own_entry_t tab [OUTSTANDING_DEPTH];
   own_entry_t tab_n [OUTSTANDING_DEPTH];
   logic [PW-1:0] rr_ptr, win_idx;
   logic [ENT_OWNER_BITS-1:0] lat_port, r_owner;
   logic [NUM_PORTS-1:0] elig, grant, id_seen, id_mine;
   logic pick_valid, hs, issue_done, free_any, iss_hit, r_hit, r_done;
   logic [IW-1:0] free_idx, iss_idx, r_idx;
   rr_picker #(.N(NUM_PORTS)) u_pick (.req(elig), .ptr(rr_ptr), .grant(grant), .valid(pick_valid));
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      iss_hit = 1'b0;
      iss_idx = '0;
      r_hit = 1'b0;
      r_idx = '0;
      r_owner = '0;
      for (int e = OUTSTANDING_DEPTH - 1; e >= 0; e--) begin
         if (!tab[e].valid) begin
            free_any = 1'b1;
            free_idx = IW'(e);
         end
         if (tab[e].valid && tab[e].id[TID_WIDTH-1:0] == m_ar_id) begin
            iss_hit = 1'b1;
            iss_idx = IW'(e);
         end
         if (tab[e].valid && tab[e].id[TID_WIDTH-1:0] == m_r_id) begin
            r_hit = 1'b1;
            r_idx = IW'(e);
            r_owner = tab[e].owner;
         end
      end
   end
   // a port whose ID is held by another port must wait to keep same-ID ordering
   always_comb begin
      id_seen = '0;
      id_mine = '0;
      elig = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int e = 0; e < OUTSTANDING_DEPTH; e++) begin
            if (tab[e].valid && tab[e].id[TID_WIDTH-1:0] == p_ar_id[i*TID_WIDTH +: TID_WIDTH]) begin
               id_seen[i] = 1'b1;
               id_mine[i] = tab[e].owner == ENT_OWNER_BITS'(i) && tab[e].cnt != CNT_FULL;
            end
         end
         elig[i] = p_ar_valid[i] && (id_seen[i] ? id_mine[i] : free_any);
      end
   end
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) if (grant[i]) win_idx = PW'(i);
   end
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= ST_ARB_IDLE;
      else state <= state_n;
   end
   always_comb
      state_n = (state == ST_ARB_IDLE) ? (pick_valid ? ST_ARB_ISSUE : ST_ARB_IDLE)
                                       : (m_ar_ready ? ST_ARB_IDLE : ST_ARB_ISSUE);
   always_comb begin
      m_ar_valid = state == ST_ARB_ISSUE;
      p_ar_ready = (state == ST_ARB_IDLE) ? grant : '0;
      hs = state == ST_ARB_IDLE && pick_valid;
      issue_done = state == ST_ARB_ISSUE && m_ar_ready;
   end
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rr_ptr <= '0;
         lat_port <= '0;
         m_ar_addr <= '0;
         m_ar_len <= '0;
         m_ar_id <= '0;
      end else if (hs) begin
         rr_ptr <= (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
         lat_port <= ENT_OWNER_BITS'(win_idx);
         m_ar_addr <= p_ar_addr[int'(win_idx)*ADDR_BITS +: ADDR_BITS];
         m_ar_len <= p_ar_len[int'(win_idx)*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
         m_ar_id <= p_ar_id[int'(win_idx)*TID_WIDTH +: TID_WIDTH];
      end
   end
   always_comb begin
      p_r_valid = '0;
      m_r_ready = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (r_hit && r_owner == ENT_OWNER_BITS'(i)) begin
            p_r_valid[i] = m_r_valid;
            m_r_ready = p_r_ready[i];
         end
      end
      r_done = m_r_valid && m_r_ready && m_r_last && r_hit;
   end
   // an issue and a last beat landing on the same entry cancel out
   always_comb begin
      for (int e = 0; e < OUTSTANDING_DEPTH; e++) begin
         tab_n[e] = tab[e];
         if (issue_done && (iss_hit ? iss_idx == IW'(e) : free_any && free_idx == IW'(e))
             && !(r_done && r_idx == IW'(e))) begin
            tab_n[e].valid = 1'b1;
            tab_n[e].id = ENT_ID_BITS'(m_ar_id);
            tab_n[e].owner = lat_port;
            tab_n[e].cnt = iss_hit ? tab[e].cnt + 1'b1 : ENT_CNT_BITS'(1);
         end else if (r_done && r_idx == IW'(e) && !(issue_done && iss_hit && iss_idx == IW'(e))) begin
            tab_n[e].cnt = tab[e].cnt - 1'b1;
            tab_n[e].valid = tab[e].cnt != ENT_CNT_BITS'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int e = 0; e < OUTSTANDING_DEPTH; e++) tab[e] <= '0;
         err_unknown_id <= 1'b0;
      end else begin
         tab <= tab_n;
         if (m_r_valid && !r_hit) err_unknown_id <= 1'b1;
      end
   end
`ifdef PREF_ARB_STATS_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stat_grants <= '0;
         stat_stalls <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++)
            if (issue_done && lat_port == ENT_OWNER_BITS'(i) && stat_grants[i*STAT_WIDTH +: STAT_WIDTH] != '1)
               stat_grants[i*STAT_WIDTH +: STAT_WIDTH] <= stat_grants[i*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
         if (|p_ar_valid && !hs && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
      end
   end
`endif
endmodule
